// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port GPR file and its busy scoreboard.
package reg_file_pkg;

  localparam int unsigned DEF_REG_FILE_BITS = 5;
  localparam int unsigned DEF_REG_SIZE      = 64;
  localparam int unsigned MAX_WR            = 4;

  typedef logic [DEF_REG_FILE_BITS-1:0] reg_addr_t;
  typedef logic [DEF_REG_SIZE-1:0]      reg_data_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } bypass_t;

  // Highest-indexed matching write port wins, mirroring the write-commit order.
  function automatic bypass_t bypass_sel(input logic [MAX_WR-1:0] match);
    bypass_t r;
    r = '0;
    for (int unsigned j = 0; j < MAX_WR; j++) begin
      if (match[j]) begin
        r.hit = 1'b1;
        r.idx = 2'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback/issue bundle between the pipeline (master) and the register file (slave).
interface reg_file_mp_if #(
  parameter int unsigned REG_FILE_BITS = 5,
  parameter int unsigned REG_SIZE      = 64,
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned NUM_WR        = 1
);

  logic [NUM_RD*REG_FILE_BITS-1:0] read_num;
  logic [NUM_RD*REG_SIZE-1:0]      to_read_data;
  logic [NUM_RD-1:0]               read_busy;
  logic [NUM_WR-1:0]               we;
  logic [NUM_WR*REG_FILE_BITS-1:0] write_num;
  logic [NUM_WR*REG_SIZE-1:0]      to_write_data;
  logic                            alloc_en;
  logic [REG_FILE_BITS-1:0]        alloc_num;
  logic [NUM_WR-1:0]               wb_clear;
  logic [(1<<REG_FILE_BITS)-1:0]   busy_vec;

  modport master (
    output read_num, we, write_num, to_write_data, alloc_en, alloc_num, wb_clear,
    input  to_read_data, read_busy, busy_vec
  );

  modport slave (
    input  read_num, we, write_num, to_write_data, alloc_en, alloc_num, wb_clear,
    output to_read_data, read_busy, busy_vec
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared on final writeback, with combinational
// release for reads that coincide with the clearing writeback.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned REG_FILE_BITS = DEF_REG_FILE_BITS,
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned NUM_WR        = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_RD*REG_FILE_BITS-1:0] read_num,
  input  logic [NUM_WR-1:0]               we,
  input  logic [NUM_WR*REG_FILE_BITS-1:0] write_num,
  input  logic [NUM_WR-1:0]               wb_clear,
  input  logic                            alloc_en,
  input  logic [REG_FILE_BITS-1:0]        alloc_num,
  output logic [NUM_RD-1:0]               read_busy,
  output logic [(1<<REG_FILE_BITS)-1:0]   busy_vec
);

  localparam int unsigned SIZE = 1 << REG_FILE_BITS;

  logic [SIZE-1:0]          busy;
  logic [SIZE-1:0]          busy_nxt;
  logic                     clr;
  logic [REG_FILE_BITS-1:0] ra;
  logic [MAX_WR-1:0]        match;
  logic [MAX_WR-1:0]        clr_pad;
  bypass_t                  sel;

  // Entry 0 is never touched, so it stays at its reset value of 0.
  always_comb begin
    busy_nxt = busy;
    clr      = 1'b0;
    for (int unsigned r = 1; r < SIZE; r++) begin
      clr = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        clr = clr | (wb_clear[j] && (write_num[j*REG_FILE_BITS +: REG_FILE_BITS] == REG_FILE_BITS'(r)));
      end
      if (alloc_en && (alloc_num == REG_FILE_BITS'(r))) begin
        busy_nxt[r] = 1'b1;
      end else if (clr) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // A final writeback on the winning bypass port releases the read in the same cycle.
  always_comb begin
    read_busy = '0;
    ra        = '0;
    match     = '0;
    sel       = '0;
    clr_pad   = MAX_WR'(wb_clear);
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra    = read_num[i*REG_FILE_BITS +: REG_FILE_BITS];
      match = '0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        match[j] = we[j] && (write_num[j*REG_FILE_BITS +: REG_FILE_BITS] == ra);
      end
      sel          = bypass_sel(match);
      read_busy[i] = (ra != '0) && busy[ra] && !(sel.hit && clr_pad[sel.idx]);
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port GPR file: posedge writes, zero-latency reads with same-cycle write bypass,
// x0 hardwired to zero, plus the busy scoreboard used for RAW stalls.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned          REG_FILE_BITS = DEF_REG_FILE_BITS,
  parameter int unsigned          REG_SIZE      = DEF_REG_SIZE,
  parameter int unsigned          NUM_RD        = 2,
  parameter int unsigned          NUM_WR        = 1,
  parameter logic [REG_SIZE-1:0]  RESET_VALUE   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_mp_if.slave  bus
);

  localparam int unsigned SIZE = 1 << REG_FILE_BITS;

  logic [REG_SIZE-1:0]      regs  [SIZE];
  logic [REG_SIZE-1:0]      wdata [MAX_WR];
  logic [NUM_RD*REG_SIZE-1:0] rd_data;
  logic [REG_FILE_BITS-1:0] ra;
  logic [MAX_WR-1:0]        match;
  bypass_t                  sel;

  // Ascending port order makes the highest-indexed port win a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < SIZE; r++) begin
        regs[r] <= RESET_VALUE;
      end
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (bus.we[j] && (bus.write_num[j*REG_FILE_BITS +: REG_FILE_BITS] != '0)) begin
          regs[bus.write_num[j*REG_FILE_BITS +: REG_FILE_BITS]] <= bus.to_write_data[j*REG_SIZE +: REG_SIZE];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < MAX_WR; j++) begin
      wdata[j] = '0;
    end
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wdata[j] = bus.to_write_data[j*REG_SIZE +: REG_SIZE];
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    match   = '0;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra    = bus.read_num[i*REG_FILE_BITS +: REG_FILE_BITS];
      match = '0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        match[j] = bus.we[j] && (bus.write_num[j*REG_FILE_BITS +: REG_FILE_BITS] == ra);
      end
      sel = bypass_sel(match);
      if (ra == '0) begin
        rd_data[i*REG_SIZE +: REG_SIZE] = '0;
      end else if (sel.hit) begin
        rd_data[i*REG_SIZE +: REG_SIZE] = wdata[sel.idx];
      end else begin
        rd_data[i*REG_SIZE +: REG_SIZE] = regs[ra];
      end
    end
  end

  assign bus.to_read_data = rd_data;

  reg_scoreboard #(
    .REG_FILE_BITS (REG_FILE_BITS),
    .NUM_RD        (NUM_RD),
    .NUM_WR        (NUM_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_num  (bus.read_num),
    .we        (bus.we),
    .write_num (bus.write_num),
    .wb_clear  (bus.wb_clear),
    .alloc_en  (bus.alloc_en),
    .alloc_num (bus.alloc_num),
    .read_busy (bus.read_busy),
    .busy_vec  (bus.busy_vec)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed corner cases plus randomized traffic against a
// behavioural register/scoreboard model checked on every falling edge.
module tb_reg_file_mp;

  localparam int B  = 5;
  localparam int W  = 64;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int SZ = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.REG_FILE_BITS(B), .REG_SIZE(W), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  reg_file_mp #(
    .REG_FILE_BITS (B),
    .REG_SIZE      (W),
    .NUM_RD        (NR),
    .NUM_WR        (NW),
    .RESET_VALUE   (64'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] m_regs [SZ];
  logic         m_busy [SZ];

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [B-1:0] rn(input int i);
    return bus.read_num[i*B +: B];
  endfunction
  function automatic logic [B-1:0] wn(input int j);
    return bus.write_num[j*B +: B];
  endfunction
  function automatic logic [W-1:0] wd(input int j);
    return bus.to_write_data[j*W +: W];
  endfunction
  function automatic logic [W-1:0] rd(input int i);
    return bus.to_read_data[i*W +: W];
  endfunction
  function automatic logic [W-1:0] rbusy(input int i);
    return W'(bus.read_busy[i]);
  endfunction
  function automatic logic [W-1:0] bvec();
    return W'(bus.busy_vec);
  endfunction

  // Reference: reads see the newest same-cycle write, else the stored value.
  function automatic logic [W-1:0] exp_rd(input int i);
    logic [B-1:0] a;
    a = rn(i);
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--) begin
      if (bus.we[j] && wn(j) == a) return wd(j);
    end
    return m_regs[a];
  endfunction

  function automatic logic [W-1:0] exp_rbusy(input int i);
    logic [B-1:0] a;
    a = rn(i);
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--) begin
      if (bus.we[j] && wn(j) == a) return W'(m_busy[a] && !bus.wb_clear[j]);
    end
    return W'(m_busy[a]);
  endfunction

  function automatic logic [W-1:0] exp_bvec();
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < SZ; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < SZ; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < NW; j++) begin
        if (bus.we[j] && wn(j) != 0) m_regs[wn(j)] = wd(j);
      end
      for (int j = 0; j < NW; j++) begin
        if (bus.wb_clear[j]) m_busy[wn(j)] = 1'b0;
      end
      if (bus.alloc_en && bus.alloc_num != 0) m_busy[bus.alloc_num] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      cmp($sformatf("rd%0d", i), rd(i), exp_rd(i));
      cmp($sformatf("read_busy%0d", i), rbusy(i), exp_rbusy(i));
    end
    cmp("busy_vec", bvec(), exp_bvec());
  end

  task automatic idle();
    bus.read_num      = '0;
    bus.we            = '0;
    bus.write_num     = '0;
    bus.to_write_data = '0;
    bus.alloc_en      = 1'b0;
    bus.alloc_num     = '0;
    bus.wb_clear      = '0;
  endtask

  task automatic set_rd(input int i, input logic [B-1:0] a);
    bus.read_num[i*B +: B] = a;
  endtask

  task automatic set_wr(input int j, input logic [B-1:0] a, input logic [W-1:0] d);
    bus.we[j]                  = 1'b1;
    bus.write_num[j*B +: B]    = a;
    bus.to_write_data[j*W +: W] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [B-1:0] raddr();
    if ($urandom_range(0, 3) == 0) return B'($urandom_range(0, SZ - 1));
    return B'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_reset();
    #12 rst_n = 1'b1;

    next_cycle();
    set_rd(0, 5);
    #1;
    cmp("reset_busy_vec", bvec(), 64'h0);
    cmp("reset_rd_x5", rd(0), 64'h0);

    // async reset drops stored data and busy state mid-cycle
    next_cycle();
    set_wr(0, 5, 64'hDEAD);
    bus.alloc_en  = 1'b1;
    bus.alloc_num = 5;
    next_cycle();
    set_rd(0, 5);
    #1;
    cmp("x5_written", rd(0), 64'hDEAD);
    cmp("x5_busy", bvec(), 64'h20);
    rst_n = 1'b0;
    #1;
    cmp("async_rst_rd", rd(0), 64'h0);
    cmp("async_rst_busy", bvec(), 64'h0);
    #1 rst_n = 1'b1;

    next_cycle();
    set_wr(0, 7, 64'h1234);
    set_rd(0, 7);
    #1;
    cmp("bypass_rd", rd(0), 64'h1234);
    next_cycle();
    set_rd(0, 7);
    #1;
    cmp("stored_x7", rd(0), 64'h1234);

    next_cycle();
    set_wr(0, 0, 64'hFFFF);
    bus.alloc_en  = 1'b1;
    bus.alloc_num = 0;
    #1;
    cmp("x0_bypass", rd(0), 64'h0);
    next_cycle();
    #1;
    cmp("x0_read", rd(0), 64'h0);
    cmp("x0_busy", bvec(), 64'h0);

    next_cycle();
    set_wr(0, 3, 64'hA);
    set_wr(1, 3, 64'hB);
    set_rd(1, 3);
    #1;
    cmp("conflict_bypass", rd(1), 64'hB);
    next_cycle();
    set_rd(1, 3);
    #1;
    cmp("conflict_stored", rd(1), 64'hB);

    next_cycle();
    bus.alloc_en  = 1'b1;
    bus.alloc_num = 9;
    set_rd(2, 9);
    #1;
    cmp("alloc_same_cycle", rbusy(2), 64'h0);
    next_cycle();
    set_rd(2, 9);
    #1;
    cmp("alloc_next_cycle", rbusy(2), 64'h1);
    cmp("busy_vec_x9", bvec(), 64'h200);
    next_cycle();
    bus.alloc_en    = 1'b1;
    bus.alloc_num   = 9;
    bus.wb_clear[0] = 1'b1;
    bus.write_num[0 +: B] = 9;
    set_rd(2, 9);
    #1;
    cmp("alloc_clear_same", rbusy(2), 64'h1);
    next_cycle();
    set_rd(2, 9);
    #1;
    cmp("alloc_wins", rbusy(2), 64'h1);
    next_cycle();
    set_wr(0, 9, 64'h99);
    bus.wb_clear[0] = 1'b1;
    set_rd(2, 9);
    #1;
    cmp("wb_unbusy", rbusy(2), 64'h0);
    cmp("wb_bypass", rd(2), 64'h99);
    next_cycle();
    set_rd(2, 9);
    #1;
    cmp("x9_released", bvec(), 64'h0);
    cmp("x9_stored", rd(2), 64'h99);

    // squashed producer: clear without write still releases
    next_cycle();
    bus.alloc_en  = 1'b1;
    bus.alloc_num = 12;
    next_cycle();
    bus.wb_clear[1] = 1'b1;
    bus.write_num[B +: B] = 12;
    set_rd(1, 12);
    #1;
    cmp("squash_still_busy", rbusy(1), 64'h1);
    next_cycle();
    set_rd(1, 12);
    #1;
    cmp("squash_released", rbusy(1), 64'h0);
    cmp("squash_busy_vec", bvec(), 64'h0);

    for (int n = 0; n < 10000; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) set_rd(i, raddr());
      for (int j = 0; j < NW; j++) begin
        bus.we[j]                   = ($urandom_range(0, 2) == 0);
        bus.write_num[j*B +: B]     = raddr();
        bus.to_write_data[j*W +: W] = {$urandom, $urandom};
        bus.wb_clear[j]             = ($urandom_range(0, 2) == 0);
      end
      bus.alloc_en  = ($urandom_range(0, 1) == 0);
      bus.alloc_num = raddr();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    next_cycle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
